data_ram_ctrl: RTL and testbench
================================

# data_ram_ctrl

Parametrised, handshaked data memory for the RV32I core's load/store path. It supports byte, halfword and word accesses with sign or zero extension, using a synchronous (BRAM-style) read. Valid/ready request and response channels replace the fixed combinational-read interface. Misaligned, out-of-range and illegal-funct3 accesses are detected and reported instead of silently aliasing.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, ≥ 2. Index width `IDX_W = $clog2(DEPTH)`.
- `INIT_BASE`, 32'h8765_4320: word `i` is initialised to `INIT_BASE + i` at time zero.
- `iClk` input 1: clock. One clock domain; reset is synchronous and active-high.
- `iRst` input 1: synchronous, active-high reset.
- `iReq_Valid` input 1: request present.
- `oReq_Ready` input→output 1: block can accept a request. Defined as `(state == IDLE) && !iRst`.
- `iReq_WrEn` input 1: 1 = store, 0 = load.
- `iFunct3` input 3: RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `iAddr` input 32: byte address.
- `iWrData` input 32: store data; low byte or low half is used for SB and SH.
- `oRsp_Valid` output 1: response present. Held until `iRsp_Ready`.
- `iRsp_Ready` input 1: consumer accepts the response.
- `oRsp_RdData` output 32: load result. 0 for stores and errors.
- `oRsp_Err` output 1: access rejected.

## Operation
- FSM states: IDLE, RD, RESP.
- Accept happens in IDLE when `iReq_Valid && oReq_Ready`. Address, funct3, WrEn and lane select are captured at that edge.
- Error check is evaluated combinationally in IDLE on the request fields. The access is in error if any of these hold:
  - halfword with `iAddr[0]`=1;
  - word with `iAddr[1:0]` ≠ 0;
  - any of `iAddr[31:IDX_W+2]` ≠ 0;
  - store funct3 outside {000, 001, 010};
  - load funct3 in {011, 110, 111}.
- Error path: IDLE → RESP. No memory write. `oRsp_Err`=1, `oRsp_RdData`=0.
- Store path: IDLE → RESP.
  - At the accept edge, the byte lanes selected by a byte-enable mask are written:
    - SB: lane `addr[1:0]` gets `iWrData[7:0]`;
    - SH: lanes {1,0} or {3,2} by `addr[1]` get `iWrData[15:0]`;
    - SW: all four lanes.
  - Unselected lanes are unchanged.
  - Response: `oRsp_Err`=0, `oRsp_RdData`=0.
- Load path: IDLE → RD → RESP.
  - At the accept edge, the word at index `addr[IDX_W+1:2]` is registered (synchronous read).
  - In RD, the lane is extracted and extended:
    - LB/LH: sign-extend from bit 7/15;
    - LBU/LHU: zero-extend;
    - LW: word unchanged.
  - The result is registered into `oRsp_RdData` at the RD→RESP edge.
- RESP: `oRsp_Valid`=1. `oRsp_RdData` and `oRsp_Err` are stable while `iRsp_Ready`=0. The transition to IDLE happens at the edge where `iRsp_Ready`=1.
- Only one transaction is in flight. `oReq_Ready`=0 in RD and RESP, so no store-to-load hazard exists.
- Memory is never cleared by reset; contents come from initialisation only.

## Timing
- Reset values, effective at the edge with `iRst`=1:
  - state IDLE;
  - `oRsp_Valid`=0, `oRsp_RdData`=0, `oRsp_Err`=0;
  - `oReq_Ready`=0 while `iRst`=1.
- Store or error: accept in cycle 0, `oRsp_Valid` high in cycle 1. The write is visible to any later read.
- Load: accept in cycle 0, RD in cycle 1, `oRsp_Valid` high in cycle 2.
- With `iRsp_Ready` tied to 1:
  - one store or error every 2 cycles;
  - one load every 3 cycles;
  - the next accept is in the cycle after the RESP handshake.
- `iReq_Valid` with `oReq_Ready`=0: request ignored. The requester must hold it until ready.
- Reset mid-RD or mid-RESP: the transaction is dropped and no response is produced. A store already committed at accept remains in memory.
- `iRst` asserted in the same cycle as a valid request: not accepted, and no write occurs.

## Test plan
- Reset defaults, `DEPTH`=256: LW 0x0C → `oRsp_RdData`=0x87654323, err 0, `oRsp_Valid` exactly 2 cycles after accept. LB 0x0D → 0x00000043.
- Sign versus zero extension: LB 0x17 → 0xFFFFFF87; LBU 0x17 → 0x00000087. LH 0x16 → 0xFFFF8765; LHU 0x16 → 0x00008765.
- Partial stores: SH 0xBEEF to 0x0A, then LW 0x08 → 0xBEEF4322. SB 0xA5 to 0x09, then LW 0x08 → 0xBEEFA522. Each store responds 1 cycle after accept.
- Errors, each giving err 1, data 0 and memory unchanged:
  - LW 0x06;
  - LH 0x05;
  - SW 0x400 (index beyond `DEPTH`);
  - store with funct3 011.
  - Afterwards, LW 0x04 → 0x87654321.
- Backpressure: a load to 0x10 with `iRsp_Ready`=0 for 4 cycles holds valid and 0x87654324 stable. `oReq_Ready` stays 0 throughout. The next request is accepted the cycle after the handshake.
- Reset in RD: accept LW 0x0C, assert `iRst` in cycle 1. Outputs are 0 the next cycle, no `oRsp_Valid` ever appears for that load, and `oReq_Ready` returns once `iRst` drops.

Source files
------------

// File: rtl/data_ram_ctrl.sv
// Handshaked RV32I data memory: byte/half/word loads and stores,
// synchronous read, and reporting of illegal or misaligned accesses.
module data_ram_ctrl #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] INIT_BASE = 32'h8765_4320,
  localparam int         IDX_W     = $clog2(DEPTH)
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq_Valid,
  output logic        oReq_Ready,
  input  logic        iReq_WrEn,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWrData,
  output logic        oRsp_Valid,
  input  logic        iRsp_Ready,
  output logic [31:0] oRsp_RdData,
  output logic        oRsp_Err
);

  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             err;
  logic             bad_f3;
  logic             hi_bad;
  logic             is_half;
  logic             is_word;
  logic             we;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      rd_word;
  logic [31:0]      ext_data;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic [2:0]       cap_f3;
  logic [1:0]       cap_lane;
  logic [31:0]      rd_bus [DEPTH];

  assign accept      = iReq_Valid && oReq_Ready;
  assign idx         = iAddr[IDX_W+1:2];
  assign we          = accept && iReq_WrEn && !err;
  assign oRsp_RdData = rsp_data;
  assign oRsp_Err    = rsp_err;

  // Request decode: legality check, lane mask and replicated store data
  always_comb begin
    is_half = (iFunct3[1:0] == 2'b01);
    is_word = (iFunct3[1:0] == 2'b10);
    hi_bad  = ((iAddr >> (IDX_W + 2)) != 32'd0);
    if (iReq_WrEn)
      bad_f3 = iFunct3[2] || (iFunct3[1:0] == 2'b11);
    else
      bad_f3 = (iFunct3[1:0] == 2'b11) || (iFunct3 == 3'b110);
    err = (is_half && iAddr[0])
       || (is_word && (iAddr[1:0] != 2'b00))
       || hi_bad || bad_f3;
    be    = 4'b0001 << iAddr[1:0];
    wdata = {4{iWrData[7:0]}};
    unique case (1'b1)
      is_word: begin
        be    = 4'b1111;
        wdata = iWrData;
      end
      is_half: begin
        be    = iAddr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{iWrData[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [31:0] word = INIT_BASE + 32'(g);
    assign rd_bus[g] = word;
    // Commit selected byte lanes of this word at the accept edge
    always_ff @(posedge iClk) begin
      if (we && (idx == IDX_W'(g))) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) word[8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Synchronous read of the addressed word plus load attributes
  always_ff @(posedge iClk) begin
    if (accept) begin
      rd_word  <= rd_bus[idx];
      cap_f3   <= iFunct3;
      cap_lane <= iAddr[1:0];
    end
  end

  // Lane extraction and sign/zero extension of the read word
  always_comb begin
    byte_v = rd_word[8*cap_lane +: 8];
    half_v = cap_lane[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (cap_f3)
      3'b000:  ext_data = {{24{byte_v[7]}}, byte_v};
      3'b001:  ext_data = {{16{half_v[15]}}, half_v};
      3'b100:  ext_data = {24'd0, byte_v};
      3'b101:  ext_data = {16'd0, half_v};
      default: ext_data = rd_word;
    endcase
  end

  // Response registers: cleared at accept, filled in RD, held in RESP
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rsp_data <= 32'd0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      rsp_data <= 32'd0;
      rsp_err  <= err;
    end else if (state == RD) begin
      rsp_data <= ext_data;
    end
  end

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nxt = (err || iReq_WrEn) ? RESP : RD;
      end
      RD:      state_nxt = RESP;
      RESP:    if (iRsp_Ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    oReq_Ready = (state == IDLE) && !iRst;
    oRsp_Valid = (state == RESP);
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl: directed requests push expected
// responses, a monitor pops and compares at each response handshake.
module tb_data_ram_ctrl;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iReq_Valid = 1'b0;
  logic        iReq_WrEn = 1'b0;
  logic [2:0]  iFunct3 = 3'b010;
  logic [31:0] iAddr = 32'd0;
  logic [31:0] iWrData = 32'd0;
  logic        iRsp_Ready = 1'b1;
  logic        oReq_Ready;
  logic        oRsp_Valid;
  logic        oRsp_Err;
  logic [31:0] oRsp_RdData;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam bit [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
  localparam bit [2:0] LBU = 3'b100, LHU = 3'b101;

  data_ram_ctrl #(.DEPTH(256), .INIT_BASE(32'h8765_4320)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .iReq_Valid(iReq_Valid),
    .oReq_Ready(oReq_Ready),
    .iReq_WrEn(iReq_WrEn),
    .iFunct3(iFunct3),
    .iAddr(iAddr),
    .iWrData(iWrData),
    .oRsp_Valid(oRsp_Valid),
    .iRsp_Ready(iRsp_Ready),
    .oRsp_RdData(oRsp_RdData),
    .oRsp_Err(oRsp_Err)
  );

  always #5 iClk = ~iClk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake is checked against the queue head
  always @(negedge iClk) begin
    if (oRsp_Valid && iRsp_Ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data %h err %b want none",
                 oRsp_RdData, oRsp_Err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_data"}, oRsp_RdData, e.data);
        chk({e.name, "_err"}, {31'd0, oRsp_Err}, {31'd0, e.err});
      end
    end
  end

  task automatic req(string name, bit wr, bit [2:0] f3,
                     bit [31:0] addr, bit [31:0] wd,
                     bit [31:0] exp_data, bit exp_err,
                     int exp_lat, int hold);
    int waits = 0;
    int lat = 0;
    iReq_Valid = 1'b1;
    iReq_WrEn  = wr;
    iFunct3    = f3;
    iAddr      = addr;
    iWrData    = wd;
    iRsp_Ready = (hold == 0);
    @(negedge iClk);
    while (!oReq_Ready && waits < 20) begin
      waits++;
      @(negedge iClk);
    end
    chk({name, "_acc_wait"}, waits, 0);
    sb.push_back('{exp_data, exp_err, name});
    @(posedge iClk);
    #1 iReq_Valid = 1'b0;
    do begin
      @(negedge iClk);
      lat++;
    end while (!oRsp_Valid && lat < 10);
    chk({name, "_lat"}, lat, exp_lat);
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge iClk);
        @(negedge iClk);
        chk({name, "_hold_valid"}, {31'd0, oRsp_Valid}, 32'd1);
        chk({name, "_hold_data"}, oRsp_RdData, exp_data);
        chk({name, "_hold_rdy"}, {31'd0, oReq_Ready}, 32'd0);
      end
      @(posedge iClk);
      #1 iRsp_Ready = 1'b1;
      @(negedge iClk);
    end
    @(posedge iClk);
    #1;
  endtask

  initial begin
    int seen;
    // Reset with a store presented: must be neither accepted nor written
    iReq_Valid = 1'b1;
    iReq_WrEn  = 1'b1;
    iFunct3    = LW;
    iAddr      = 32'h20;
    iWrData    = 32'h0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    chk("rst_valid", {31'd0, oRsp_Valid}, 32'd0);
    chk("rst_data", oRsp_RdData, 32'd0);
    chk("rst_err", {31'd0, oRsp_Err}, 32'd0);
    chk("rst_ready", {31'd0, oReq_Ready}, 32'd0);
    @(posedge iClk);
    #1 iRst = 1'b0;
    iReq_Valid = 1'b0;
    req("rst_nowrite", 0, LW, 32'h20, 0, 32'h8765_4328, 0, 2, 0);

    req("lw_0c", 0, LW, 32'h0C, 0, 32'h8765_4323, 0, 2, 0);
    req("lb_0d", 0, LB, 32'h0D, 0, 32'h0000_0043, 0, 2, 0);
    req("lb_17", 0, LB, 32'h17, 0, 32'hFFFF_FF87, 0, 2, 0);
    req("lbu_17", 0, LBU, 32'h17, 0, 32'h0000_0087, 0, 2, 0);
    req("lh_16", 0, LH, 32'h16, 0, 32'hFFFF_8765, 0, 2, 0);
    req("lhu_16", 0, LHU, 32'h16, 0, 32'h0000_8765, 0, 2, 0);

    req("sh_0a", 1, 3'b001, 32'h0A, 32'h1234_BEEF, 0, 0, 1, 0);
    req("lw_08a", 0, LW, 32'h08, 0, 32'hBEEF_4322, 0, 2, 0);
    req("sb_09", 1, 3'b000, 32'h09, 32'h7777_77A5, 0, 0, 1, 0);
    req("lw_08b", 0, LW, 32'h08, 0, 32'hBEEF_A522, 0, 2, 0);

    req("err_lw06", 0, LW, 32'h06, 0, 0, 1, 1, 0);
    req("err_lh05", 0, LH, 32'h05, 0, 0, 1, 1, 0);
    req("err_sw400", 1, 3'b010, 32'h400, 32'hDEAD_BEEF, 0, 1, 1, 0);
    req("err_st011", 1, 3'b011, 32'h20, 32'hDEAD_BEEF, 0, 1, 1, 0);
    req("lw_04", 0, LW, 32'h04, 0, 32'h8765_4321, 0, 2, 0);
    req("lw_00", 0, LW, 32'h00, 0, 32'h8765_4320, 0, 2, 0);
    req("lw_20", 0, LW, 32'h20, 0, 32'h8765_4328, 0, 2, 0);

    req("bp_lw10", 0, LW, 32'h10, 0, 32'h8765_4324, 0, 2, 4);
    req("bp_next", 0, LW, 32'h0C, 0, 32'h8765_4323, 0, 2, 0);

    // Reset while the load sits in RD: no response may ever appear
    iReq_Valid = 1'b1;
    iReq_WrEn  = 1'b0;
    iFunct3    = LW;
    iAddr      = 32'h0C;
    @(negedge iClk);
    chk("rrd_acc_rdy", {31'd0, oReq_Ready}, 32'd1);
    @(posedge iClk);
    #1 iReq_Valid = 1'b0;
    iRst = 1'b1;
    @(negedge iClk);
    chk("rrd_in_rd_rdy", {31'd0, oReq_Ready}, 32'd0);
    @(posedge iClk);
    @(negedge iClk);
    chk("rrd_valid", {31'd0, oRsp_Valid}, 32'd0);
    chk("rrd_data", oRsp_RdData, 32'd0);
    chk("rrd_err", {31'd0, oRsp_Err}, 32'd0);
    chk("rrd_rdy_in_rst", {31'd0, oReq_Ready}, 32'd0);
    @(posedge iClk);
    #1 iRst = 1'b0;
    @(negedge iClk);
    chk("rrd_rdy_back", {31'd0, oReq_Ready}, 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge iClk);
      if (oRsp_Valid) seen++;
    end
    chk("rrd_no_rsp", seen, 0);
    @(posedge iClk);
    #1;
    req("after_rst", 0, LH, 32'h0E, 0, 32'hFFFF_8765, 0, 2, 0);

    repeat (3) @(posedge iClk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
